// File: rtl/clint_trap_ctrl.sv
// Trap sequencer for the machine-mode CLINT CSR write port: mepc, mcause, [mtval], mstatus, redirect.
// Optional mtval write stage enabled by defining CLINT_MTVAL_EN.
module clint_trap_ctrl #(
    parameter logic [63:0] MTVEC_MODE_MASK = 64'hFFFF_FFFF_FFFF_FFFC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmt_valid_i,
    input  logic [63:0] cmt_pc_i,
    input  logic [31:0] cmt_inst_i,
    input  logic        cmt_ecall_i,
    input  logic        cmt_mret_i,
    input  logic        global_int_en_i,
    input  logic        mtime_int_en_i,
    input  logic        mtime_int_pend_i,
    input  logic [63:0] csr_mtvec_i,
    input  logic [63:0] csr_mepc_i,
    input  logic [63:0] csr_mstatus_i,
    output logic        clint_csr_wen_o,
    output logic [11:0] clint_csr_waddr_o,
    output logic [63:0] clint_csr_wdata_o,
    output logic        stall_o,
    output logic        flush_o,
    output logic        redirect_valid_o,
    output logic [63:0] redirect_pc_o,
    output logic        busy_o
);

`ifdef CLINT_MTVAL_EN
    typedef enum logic [2:0] {StIdle, StMepc, StMcause, StMtval, StMstatus, StRedirect} state_e;
`else
    typedef enum logic [2:0] {StIdle, StMepc, StMcause, StMstatus, StRedirect} state_e;
`endif

    state_e      state_q;
    logic [63:0] pc_q;
    logic [63:0] cause_q;
    logic        kind_q;  // 1: mret, 0: trap

    logic irq;
    logic accept;

    assign irq    = global_int_en_i & mtime_int_en_i & mtime_int_pend_i;
    // Reset gating keeps stall_o low while rst is held even if an event is presented.
    assign accept = (state_q == StIdle) & cmt_valid_i & (irq | cmt_ecall_i | cmt_mret_i) & ~rst;

`ifdef CLINT_MTVAL_EN
    logic [31:0] inst_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_q <= 32'd0;
        end else if (accept) begin
            inst_q <= cmt_inst_i;
        end
    end
`else
    logic unused_inst;
    assign unused_inst = ^cmt_inst_i;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            pc_q    <= 64'd0;
            cause_q <= 64'd0;
            kind_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        pc_q    <= cmt_pc_i;
                        cause_q <= irq ? 64'h8000_0000_0000_0007 :
                                   (cmt_ecall_i ? 64'd11 : 64'd0);
                        kind_q  <= ~(irq | cmt_ecall_i);
                        state_q <= (irq | cmt_ecall_i) ? StMepc : StMstatus;
                    end
                end
                StMepc:     state_q <= StMcause;
`ifdef CLINT_MTVAL_EN
                StMcause:   state_q <= StMtval;
                StMtval:    state_q <= StMstatus;
`else
                StMcause:   state_q <= StMstatus;
`endif
                StMstatus:  state_q <= StRedirect;
                StRedirect: state_q <= StIdle;
                default:    state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        clint_csr_wen_o   = 1'b0;
        clint_csr_waddr_o = 12'h000;
        clint_csr_wdata_o = 64'd0;
        flush_o           = 1'b0;
        redirect_valid_o  = 1'b0;
        redirect_pc_o     = 64'd0;
        unique case (state_q)
            StMepc: begin
                clint_csr_wen_o   = 1'b1;
                clint_csr_waddr_o = 12'h341;
                clint_csr_wdata_o = {pc_q[63:2], 2'b00};
            end
            StMcause: begin
                clint_csr_wen_o   = 1'b1;
                clint_csr_waddr_o = 12'h342;
                clint_csr_wdata_o = cause_q;
            end
`ifdef CLINT_MTVAL_EN
            StMtval: begin
                clint_csr_wen_o   = 1'b1;
                clint_csr_waddr_o = 12'h343;
                clint_csr_wdata_o = cause_q[63] ? 64'd0 : {32'd0, inst_q};
            end
`endif
            StMstatus: begin
                clint_csr_wen_o   = 1'b1;
                clint_csr_waddr_o = 12'h300;
                clint_csr_wdata_o = csr_mstatus_i;
                if (kind_q) begin
                    clint_csr_wdata_o[3] = csr_mstatus_i[7];
                    clint_csr_wdata_o[7] = 1'b1;
                end else begin
                    clint_csr_wdata_o[7] = csr_mstatus_i[3];
                    clint_csr_wdata_o[3] = 1'b0;
                end
                clint_csr_wdata_o[12:11] = 2'b11;
            end
            StRedirect: begin
                flush_o          = 1'b1;
                redirect_valid_o = 1'b1;
                redirect_pc_o    = kind_q ? csr_mepc_i : (csr_mtvec_i & MTVEC_MODE_MASK);
            end
            default: ;
        endcase
    end

    assign busy_o  = (state_q != StIdle);
    assign stall_o = busy_o | accept;

endmodule

// File: tb/tb_clint_trap_ctrl.sv
// Directed bench for clint_trap_ctrl: irq, ecall, mret, irq+ecall priority, mid-sequence reset.
module tb_clint_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmt_valid_i;
    logic [63:0] cmt_pc_i;
    logic [31:0] cmt_inst_i;
    logic        cmt_ecall_i;
    logic        cmt_mret_i;
    logic        global_int_en_i;
    logic        mtime_int_en_i;
    logic        mtime_int_pend_i;
    logic [63:0] csr_mtvec_i;
    logic [63:0] csr_mepc_i;
    logic [63:0] csr_mstatus_i;
    logic        clint_csr_wen_o;
    logic [11:0] clint_csr_waddr_o;
    logic [63:0] clint_csr_wdata_o;
    logic        stall_o;
    logic        flush_o;
    logic        redirect_valid_o;
    logic [63:0] redirect_pc_o;
    logic        busy_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    clint_trap_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .cmt_valid_i       (cmt_valid_i),
        .cmt_pc_i          (cmt_pc_i),
        .cmt_inst_i        (cmt_inst_i),
        .cmt_ecall_i       (cmt_ecall_i),
        .cmt_mret_i        (cmt_mret_i),
        .global_int_en_i   (global_int_en_i),
        .mtime_int_en_i    (mtime_int_en_i),
        .mtime_int_pend_i  (mtime_int_pend_i),
        .csr_mtvec_i       (csr_mtvec_i),
        .csr_mepc_i        (csr_mepc_i),
        .csr_mstatus_i     (csr_mstatus_i),
        .clint_csr_wen_o   (clint_csr_wen_o),
        .clint_csr_waddr_o (clint_csr_waddr_o),
        .clint_csr_wdata_o (clint_csr_wdata_o),
        .stall_o           (stall_o),
        .flush_o           (flush_o),
        .redirect_valid_o  (redirect_valid_o),
        .redirect_pc_o     (redirect_pc_o),
        .busy_o            (busy_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_write(input string tag, input logic [11:0] addr, input logic [63:0] data);
        chk({tag, "_wen"}, 64'(clint_csr_wen_o), 64'd1);
        chk({tag, "_addr"}, 64'(clint_csr_waddr_o), 64'(addr));
        chk({tag, "_data"}, clint_csr_wdata_o, data);
        chk({tag, "_rdv"}, 64'(redirect_valid_o), 64'd0);
        chk({tag, "_rpc"}, redirect_pc_o, 64'd0);
        chk({tag, "_stall"}, 64'(stall_o), 64'd1);
    endtask

    task automatic expect_redirect(input string tag, input logic [63:0] pc);
        chk({tag, "_rdv"}, 64'(redirect_valid_o), 64'd1);
        chk({tag, "_flush"}, 64'(flush_o), 64'd1);
        chk({tag, "_rpc"}, redirect_pc_o, pc);
        chk({tag, "_wen"}, 64'(clint_csr_wen_o), 64'd0);
        chk({tag, "_addr"}, 64'(clint_csr_waddr_o), 64'd0);
        chk({tag, "_data"}, clint_csr_wdata_o, 64'd0);
        chk({tag, "_busy"}, 64'(busy_o), 64'd1);
    endtask

    task automatic expect_quiet(input string tag);
        chk({tag, "_wen"}, 64'(clint_csr_wen_o), 64'd0);
        chk({tag, "_addr"}, 64'(clint_csr_waddr_o), 64'd0);
        chk({tag, "_data"}, clint_csr_wdata_o, 64'd0);
        chk({tag, "_stall"}, 64'(stall_o), 64'd0);
        chk({tag, "_flush"}, 64'(flush_o), 64'd0);
        chk({tag, "_rdv"}, 64'(redirect_valid_o), 64'd0);
        chk({tag, "_rpc"}, redirect_pc_o, 64'd0);
        chk({tag, "_busy"}, 64'(busy_o), 64'd0);
    endtask

    initial begin
        rst              = 1'b1;
        cmt_valid_i      = 1'b0;
        cmt_pc_i         = 64'd0;
        cmt_inst_i       = 32'd0;
        cmt_ecall_i      = 1'b0;
        cmt_mret_i       = 1'b0;
        global_int_en_i  = 1'b0;
        mtime_int_en_i   = 1'b0;
        mtime_int_pend_i = 1'b0;
        csr_mtvec_i      = 64'h8000_0101;
        csr_mepc_i       = 64'd0;
        csr_mstatus_i    = 64'h1888;

        tick();
        tick();
        expect_quiet("reset");
        rst = 1'b0;
        tick();
        expect_quiet("idle");

        // Timer interrupt
        global_int_en_i  = 1'b1;
        mtime_int_en_i   = 1'b1;
        mtime_int_pend_i = 1'b1;
        cmt_valid_i      = 1'b1;
        cmt_pc_i         = 64'h8000_0010;
        cmt_inst_i       = 32'hDEAD_BEEF;
        #1;
        chk("irq_T_stall", 64'(stall_o), 64'd1);
        chk("irq_T_wen", 64'(clint_csr_wen_o), 64'd0);
        chk("irq_T_busy", 64'(busy_o), 64'd0);
        tick();
        cmt_valid_i      = 1'b0;
        mtime_int_pend_i = 1'b0;
        expect_write("irq_mepc", 12'h341, 64'h8000_0010);
        tick();
        expect_write("irq_mcause", 12'h342, 64'h8000_0000_0000_0007);
`ifdef CLINT_MTVAL_EN
        tick();
        expect_write("irq_mtval", 12'h343, 64'd0);
`endif
        tick();
        expect_write("irq_mstatus", 12'h300, 64'h1880);
        tick();
        expect_redirect("irq_redir", 64'h8000_0100);
        tick();
        expect_quiet("irq_done");

        // ecall; unaligned pc checks the mepc low-bit clear
        cmt_valid_i   = 1'b1;
        cmt_ecall_i   = 1'b1;
        cmt_pc_i      = 64'h8000_0042;
        cmt_inst_i    = 32'h0000_0073;
        csr_mtvec_i   = 64'h0000_0000_8000_2003;
        csr_mstatus_i = 64'h0000_0000_0000_0080;
        #1;
        chk("ecall_T_stall", 64'(stall_o), 64'd1);
        tick();
        cmt_valid_i = 1'b0;
        cmt_ecall_i = 1'b0;
        expect_write("ecall_mepc", 12'h341, 64'h8000_0040);
        tick();
        expect_write("ecall_mcause", 12'h342, 64'd11);
`ifdef CLINT_MTVAL_EN
        tick();
        expect_write("ecall_mtval", 12'h343, 64'h73);
`endif
        tick();
        expect_write("ecall_mstatus", 12'h300, 64'h1800);
        tick();
        expect_redirect("ecall_redir", 64'h8000_2000);
        chk("ecall_redir_stall", 64'(stall_o), 64'd1);
        tick();
        expect_quiet("ecall_done");

        // mret
        csr_mstatus_i = 64'h1880;
        csr_mepc_i    = 64'h8000_0044;
        cmt_valid_i   = 1'b1;
        cmt_mret_i    = 1'b1;
        cmt_pc_i      = 64'h8000_0200;
        #1;
        chk("mret_T_stall", 64'(stall_o), 64'd1);
        tick();
        cmt_valid_i = 1'b0;
        cmt_mret_i  = 1'b0;
        expect_write("mret_mstatus", 12'h300, 64'h1888);
        tick();
        expect_redirect("mret_redir", 64'h8000_0044);
        tick();
        expect_quiet("mret_done");

        // irq and ecall together; pipeline holds the ecall through the trap
        csr_mstatus_i    = 64'h1888;
        csr_mtvec_i      = 64'h8000_0101;
        mtime_int_pend_i = 1'b1;
        cmt_valid_i      = 1'b1;
        cmt_ecall_i      = 1'b1;
        cmt_pc_i         = 64'h8000_0300;
        tick();
        expect_write("both_mepc", 12'h341, 64'h8000_0300);
        tick();
        expect_write("both_mcause", 12'h342, 64'h8000_0000_0000_0007);
`ifdef CLINT_MTVAL_EN
        tick();
        expect_write("both_mtval", 12'h343, 64'd0);
`endif
        tick();
        expect_write("both_mstatus", 12'h300, 64'h1880);
        global_int_en_i = 1'b0;
        csr_mstatus_i   = 64'h1880;
        tick();
        expect_redirect("both_redir", 64'h8000_0100);
        cmt_pc_i = 64'h8000_0100;
        tick();
        chk("both_reaccept_busy", 64'(busy_o), 64'd0);
        chk("both_reaccept_stall", 64'(stall_o), 64'd1);
        tick();
        cmt_valid_i = 1'b0;
        cmt_ecall_i = 1'b0;
        expect_write("both_ecall_mepc", 12'h341, 64'h8000_0100);
        tick();
        expect_write("both_ecall_mcause", 12'h342, 64'd11);
        for (int i = 0; i < 8; i++) tick();
        expect_quiet("both_done");

        // Reset in the middle of a trap
        global_int_en_i  = 1'b1;
        mtime_int_pend_i = 1'b1;
        csr_mstatus_i    = 64'h1888;
        cmt_valid_i      = 1'b1;
        cmt_pc_i         = 64'h8000_0500;
        tick();
        expect_write("rst_mepc", 12'h341, 64'h8000_0500);
        tick();
        expect_write("rst_mcause", 12'h342, 64'h8000_0000_0000_0007);
        #2;
        rst = 1'b1;
        #1;
        expect_quiet("rst_async");
        tick();
        expect_quiet("rst_held");
        cmt_valid_i      = 1'b0;
        mtime_int_pend_i = 1'b0;
        rst              = 1'b0;
        tick();
        expect_quiet("rst_after");
        tick();
        expect_quiet("rst_after2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clint_trap_ctrl.md
# clint_trap_ctrl

Trap sequencer for the machine-mode CSR file's CLINT write port. It detects machine-timer interrupts, `ecall` and `mret` at the commit stage and stalls the pipeline. It then issues the required CSR updates one per cycle over the single CLINT write port (mepc, mcause, optionally mtval, mstatus) and redirects the PC to mtvec or mepc. It sits between the commit stage, the CSR file and the fetch unit.

## Interface
Parameters:
- `MTVEC_MODE_MASK`, 64'hFFFF_FFFF_FFFF_FFFC: mask applied to mtvec to form the trap target; direct mode only.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset
- `cmt_valid_i`  in  1  commit-stage instruction valid
- `cmt_pc_i`  in  64  PC of the commit-stage instruction
- `cmt_inst_i`  in  32  instruction word (used only with `CLINT_MTVAL_EN`)
- `cmt_ecall_i`  in  1  commit instruction is `ecall`
- `cmt_mret_i`  in  1  commit instruction is `mret`
- `global_int_en_i`  in  1  mstatus.MIE
- `mtime_int_en_i`  in  1  mie.MTIE
- `mtime_int_pend_i`  in  1  mip.MTIP
- `csr_mtvec_i`, `csr_mepc_i`, `csr_mstatus_i`  in  64 each  current CSR values
- `clint_csr_wen_o`  out  1  CLINT CSR write enable
- `clint_csr_waddr_o`  out  12  CLINT CSR write address
- `clint_csr_wdata_o`  out  64  CLINT CSR write data
- `stall_o`  out  1  hold the pipeline; the CPU gates its own CSR write enable with it
- `flush_o`  out  1  flush the pipeline, asserted in the same cycle as the redirect
- `redirect_valid_o`  out  1  PC redirect strobe
- `redirect_pc_o`  out  64  redirect target
- `busy_o`  out  1  FSM not in IDLE

## Operation
- States: IDLE, W_MEPC, W_MCAUSE, W_MTVAL (macro only), W_MSTATUS, REDIRECT.
- Events are evaluated only in IDLE and only when `cmt_valid_i`=1:
  - `irq` = `global_int_en_i & mtime_int_en_i & mtime_int_pend_i`
  - Priority: irq > ecall > mret.
- Accepting an event latches the following registers:
  - `pc_q` ← `cmt_pc_i`
  - `cause_q` ← 64'h8000_0000_0000_0007 for irq, 64'd11 for ecall
  - `kind_q` ← trap or mret
  - `inst_q` ← `cmt_inst_i`
- Trap path: IDLE → W_MEPC → W_MCAUSE → [W_MTVAL] → W_MSTATUS → REDIRECT → IDLE.
- mret path: IDLE → W_MSTATUS → REDIRECT → IDLE.
- Writes, one per state, with `clint_csr_wen_o`=1:
  - W_MEPC: address 12'h341, data `pc_q` with bits [1:0] forced to 0.
  - W_MCAUSE: address 12'h342, data `cause_q`.
  - W_MSTATUS, trap: address 12'h300, data = `csr_mstatus_i` with MPIE[7]←MIE[3], MIE[3]←0, MPP[12:11]←2'b11.
  - W_MSTATUS, mret: address 12'h300, data = `csr_mstatus_i` with MIE[3]←MPIE[7], MPIE[7]←1, MPP[12:11]←2'b11.
  - All other mstatus bits pass through unchanged.
- REDIRECT asserts `redirect_valid_o`=1 and `flush_o`=1 for exactly one cycle:
  - Trap target: `csr_mtvec_i & MTVEC_MODE_MASK`.
  - mret target: `csr_mepc_i`, which is sampled in REDIRECT.
- `stall_o` = (state≠IDLE) | (IDLE & event accepted). This is combinational, so the accepting instruction never commits a CPU CSR write.
- Events outside IDLE are ignored. The stalled pipeline holds them, and they are re-evaluated on return to IDLE. An interrupt is re-checked against the updated MIE, so no nested trap occurs.

## Timing
- The event is accepted in cycle T.
- Trap:
  - mepc write in T+1, mcause in T+2, mstatus in T+3.
  - Redirect in T+4; IDLE in T+5.
  - With `CLINT_MTVAL_EN`, everything from mstatus onward moves one cycle later.
- mret: mstatus write in T+1, redirect in T+2.
- `redirect_pc_o`, `clint_csr_waddr_o` and `clint_csr_wdata_o` are 0 whenever the matching strobe is low.
- Reset, asynchronous and taken at any point including mid-sequence:
  - State forced to IDLE.
  - All outputs 0.
  - Latched registers cleared.
  - No partial write completes after reset is asserted.

## Configuration
- `CLINT_MTVAL_EN`
  - Defined: the W_MTVAL state exists and writes address 12'h343 with 0 for irq, or with zero-extended `inst_q` for ecall.
  - Undefined: the state is removed, mtval is never written, and `cmt_inst_i` is unused.

## Test plan
- Timer irq with MIE=1, MTIE=1, MTIP=1, pc=64'h8000_0010, mtvec=64'h8000_0101, mstatus=64'h1888:
  - Writes mepc=64'h8000_0010, then mcause=64'h8000_0000_0000_0007, then mstatus=64'h1880.
  - Redirect to 64'h8000_0100 at T+4.
- ecall at pc=64'h8000_0040: mcause=11, mepc=64'h8000_0040, redirect at T+4, `stall_o` high for T..T+4.
- mret with mstatus=64'h1880, mepc=64'h8000_0044: mstatus write=64'h1888 at T+1, redirect to 64'h8000_0044 at T+2.
- irq and ecall in the same cycle: the irq cause is written; the ecall is taken on return to IDLE only after the handler's instruction stream presents it again.
- `rst` asserted at T+2 of a trap: all outputs 0 immediately, no mstatus write; after release, IDLE with `busy_o`=0.
- With `CLINT_MTVAL_EN`, ecall inst=32'h0000_0073: mtval write=64'h73 at T+3, redirect at T+5.
